// File: rtl/audio_pkg.sv
// Shared audio definitions: sample width default, frame geometry, the
// IDLE/RUN state encoding and a helper that builds a left-justified frame.
package audio_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int FRAME_BITS   = 32;
  localparam int CH_BITS      = FRAME_BITS / 2;
  localparam int BITCNT_W     = $clog2(FRAME_BITS);

  // Two-state controller encoding, kept as plain constants so older blocks
  // that compare against raw bit patterns keep working.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef logic [CH_BITS-1:0]    slot_t;
  typedef logic [FRAME_BITS-1:0] frame_t;

  // Left channel occupies the first half of the frame, right the second.
  function automatic frame_t pack_frame(input slot_t left, input slot_t right);
    return {left, right};
  endfunction

endpackage

// File: rtl/audio_bclk_gen.sv
// Codec bit-clock generator: a divider that toggles the bit clock every
// BCLK_HALF system cycles, plus a strobe marking the high-to-low toggle.
module audio_bclk_gen #(
  parameter int BCLK_HALF = 16
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic clr_i,     // hold divider at 0 and bit clock low
  output logic bclk_o,
  output logic fall_o     // this cycle's edge drives the bit clock low
);

  localparam int DIV_W = (BCLK_HALF > 2) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  // Next-state for the divider and bit clock.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (an unassigned path would infer a latch).
    div_d  = div_q;
    bclk_d = bclk_q;
    if (clr_i) begin
      div_d  = '0;
      bclk_d = 1'b0;
    end else if (tick) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      div_d  = div_q + 1'b1;
    end
  end

  // Divider and bit-clock registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk_o = bclk_q;
  assign fall_o = tick & bclk_q & ~clr_i;

endmodule

// File: rtl/audio_dac_lj_tx.sv
// Left-justified audio DAC transmitter: accepts stereo sample pairs into a
// one-deep holding register and serialises them MSB first, 16 bit-clock
// periods per channel, with the frame clock high for the left channel.
module audio_dac_lj_tx
  import audio_pkg::*;
#(
  parameter int BCLK_HALF = 16,
  parameter int SAMPLE_W  = SAMPLE_W_DEF   // at most CH_BITS
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic                iENABLE,
  input  logic [SAMPLE_W-1:0] iL_DATA,
  input  logic [SAMPLE_W-1:0] iR_DATA,
  input  logic                iVALID,
  output logic                oREADY,
  output logic                oAUD_BCLK,
  output logic                oAUD_DACLRCK,
  output logic                oAUD_DACDAT,
  output logic                oUNDERRUN
);

  localparam int PAD = CH_BITS - SAMPLE_W;
  localparam logic [BITCNT_W-1:0] BIT_LAST = BITCNT_W'(FRAME_BITS - 1);

  logic [0:0]          state_q, state_d;
  logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
  frame_t              shift_q, shift_d;
  frame_t              hold_q, hold_d;
  logic                full_q, full_d;
  logic                underrun_q, underrun_d;

  logic  running;      // currently in RUN
  logic  run_stay;     // in RUN and staying there after this edge
  logic  enter;        // IDLE -> RUN on this edge
  logic  bclk, bclk_fall;
  logic  frame_load;
  logic  accept;
  slot_t l_slot, r_slot;

  assign running  = (state_q == ST_RUN);
  assign run_stay = running & iENABLE;
  assign enter    = (state_q == ST_IDLE) & iENABLE;

  // The divider runs only while RUN continues; entering or leaving RUN
  // restarts it with the bit clock low.
  audio_bclk_gen #(
    .BCLK_HALF (BCLK_HALF)
  ) u_bclk_gen (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .clr_i  (~run_stay),
    .bclk_o (bclk),
    .fall_o (bclk_fall)
  );

  // Samples are placed at the top of each 16-bit channel slot.
  assign l_slot = slot_t'(iL_DATA) << PAD;
  assign r_slot = slot_t'(iR_DATA) << PAD;

  assign oREADY     = running & ~full_q;
  assign accept     = iVALID & oREADY & run_stay;
  assign frame_load = enter | (run_stay & bclk_fall & (bitcnt_q == BIT_LAST));

  // Next-state for controller, bit counter, shifter and holding register.
  always_comb begin
    state_d    = iENABLE ? ST_RUN : ST_IDLE;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    full_d     = full_q;
    underrun_d = 1'b0;

    if (!run_stay) begin
      // Idle, entering or aborting: everything restarts from a clean frame.
      bitcnt_d = '0;
      shift_d  = '0;
      hold_d   = '0;
      full_d   = 1'b0;
    end else begin
      if (bclk_fall) begin
        bitcnt_d = bitcnt_q + 1'b1;
        shift_d  = {shift_q[FRAME_BITS-2:0], 1'b0};
      end
      if (accept) begin
        hold_d = pack_frame(l_slot, r_slot);
        full_d = 1'b1;
      end
    end

    // A load consumes the held pair; an accept can only coincide with a load
    // when the register was empty, so that pair waits for the next frame.
    if (frame_load) begin
      shift_d    = full_q ? hold_q : '0;
      underrun_d = ~full_q;
      if (full_q) begin
        full_d = 1'b0;
      end
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      // NOTE: the holding register is cleared like any control register; its
      // contents are meaningless without full_q, but a defined value keeps the
      // serial output clean after reset.
      hold_q     <= '0;
      full_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      underrun_q <= underrun_d;
    end
  end

  assign oAUD_BCLK    = bclk;
  assign oAUD_DACLRCK = running & ~bitcnt_q[BITCNT_W-1];
  assign oAUD_DACDAT  = shift_q[FRAME_BITS-1];
  assign oUNDERRUN    = underrun_q;

endmodule

// File: tb/tb_audio_dac_lj_tx.sv
// Bench for audio_dac_lj_tx: a driver offers sample pairs and records, for
// each accepted pair, the frame it must appear in; a monitor decodes the
// serial stream on bit-clock rises and compares each completed frame.
`timescale 1ns/1ps
module tb_audio_dac_lj_tx;

  localparam int BH        = 16;
  localparam int BIT_CYC   = 2 * BH;
  localparam int FRAME_CYC = 32 * BIT_CYC;

  localparam int M_NONE    = 0;  // never offer
  localparam int M_ONE     = 1;  // keep whatever was preloaded until taken
  localparam int M_COUNT   = 2;  // always valid, counting samples
  localparam int M_RAND    = 3;  // random pairs with random gaps
  localparam int M_AT_LOAD = 4;  // offer exactly on the frame-2 load edge

  typedef struct {
    int          frame;
    logic [31:0] data;
  } exp_t;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iENABLE = 1'b0;
  logic        iVALID = 1'b0;
  logic [15:0] iL_DATA = '0;
  logic [15:0] iR_DATA = '0;
  logic        oREADY, oAUD_BCLK, oAUD_DACLRCK, oAUD_DACDAT, oUNDERRUN;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;          // posedges seen so far
  int   run_edge = 0;     // posedge on which RUN was entered
  int   epoch = 0;        // bumps on every RUN entry
  int   frames_done = 0;  // frames completed by the monitor in this run
  exp_t sb[$];

  audio_dac_lj_tx #(
    .BCLK_HALF (BH),
    .SAMPLE_W  (16)
  ) dut (
    .iCLK         (iCLK),
    .iRST_N       (iRST_N),
    .iENABLE      (iENABLE),
    .iL_DATA      (iL_DATA),
    .iR_DATA      (iR_DATA),
    .iVALID       (iVALID),
    .oREADY       (oREADY),
    .oAUD_BCLK    (oAUD_BCLK),
    .oAUD_DACLRCK (oAUD_DACLRCK),
    .oAUD_DACDAT  (oAUD_DACDAT),
    .oUNDERRUN    (oUNDERRUN)
  );

  always #10 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic outputs_idle(input string name);
    check(name, {59'd0, oAUD_BCLK, oAUD_DACLRCK, oAUD_DACDAT, oREADY, oUNDERRUN}, 64'd0);
  endtask

  task automatic run_start();
    @(negedge iCLK);
    iENABLE  = 1'b1;
    run_edge = cyc + 1;
    epoch++;
  endtask

  // Drive the source for nframes frames of the current run, then drop
  // iENABLE just after the last bit of the last frame.
  task automatic stream(input int nframes, input int mode);
    int   stop_at;
    int   cnt;
    bit   took;
    exp_t e;
    stop_at = run_edge + nframes * FRAME_CYC - 8;
    cnt     = 1;
    took    = 1'b0;
    forever begin
      @(negedge iCLK);
      if (cyc >= stop_at) break;
      if (took) begin
        iVALID = 1'b0;
        took   = 1'b0;
      end
      case (mode)
        M_COUNT: if (!iVALID) begin
          iL_DATA = 16'(cnt);
          iR_DATA = ~16'(cnt);
          iVALID  = 1'b1;
          cnt++;
        end
        M_RAND: if (!iVALID && $urandom_range(0, 2) == 0) begin
          iL_DATA = 16'($urandom);
          iR_DATA = 16'($urandom);
          iVALID  = 1'b1;
        end
        M_AT_LOAD: if (cyc == run_edge + 2 * FRAME_CYC - 1) begin
          iL_DATA = 16'h1234;
          iR_DATA = 16'h8001;
          iVALID  = 1'b1;
        end
        M_NONE: if ((cyc - run_edge) % FRAME_CYC == FRAME_CYC / 2)
          check("ready_while_empty", oREADY, 1);
        default: ;
      endcase
      // The next posedge takes the pair; it belongs to the first frame whose
      // load edge comes strictly after that posedge.
      if (iVALID && oREADY) begin
        e.frame = (cyc + 1 - run_edge) / FRAME_CYC + 1;
        e.data  = {iL_DATA, iR_DATA};
        sb.push_back(e);
        took = 1'b1;
      end
    end
    iENABLE = 1'b0;
    iVALID  = 1'b0;
    check("frames_per_run", frames_done, nframes);
    sb.delete();
    @(negedge iCLK);
    outputs_idle("after_stop");
  endtask

  // Monitor: decode bits on bit-clock rises and score each frame.
  initial begin : monitor
    int          seen_epoch;
    int          bit_idx;
    int          frame_idx;
    int          ur_cnt;
    logic        prev_bclk;
    logic [31:0] word;
    logic [31:0] exp_data;
    int          exp_ur;
    seen_epoch = 0;
    bit_idx    = 0;
    frame_idx  = 0;
    ur_cnt     = 0;
    prev_bclk  = 1'b0;
    word       = '0;
    forever begin
      @(negedge iCLK);
      if (epoch != seen_epoch) begin
        seen_epoch  = epoch;
        bit_idx     = 0;
        frame_idx   = 0;
        ur_cnt      = 0;
        word        = '0;
        frames_done = 0;
      end
      if (oUNDERRUN === 1'b1) ur_cnt++;
      if (oAUD_BCLK === 1'b1 && prev_bclk === 1'b0) begin
        check("bclk_rise_time", cyc, run_edge + frame_idx * FRAME_CYC + BH + bit_idx * BIT_CYC);
        check("lrck_at_rise", oAUD_DACLRCK, (bit_idx < 16));
        word = {word[30:0], oAUD_DACDAT};
        bit_idx++;
        if (bit_idx == 32) begin
          if (sb.size() > 0 && sb[0].frame == frame_idx) begin
            exp_data = sb[0].data;
            void'(sb.pop_front());
            exp_ur   = 0;
          end else begin
            exp_data = '0;
            exp_ur   = 1;
          end
          check("frame_data", word, exp_data);
          check("frame_underrun", ur_cnt, exp_ur);
          ur_cnt  = 0;
          bit_idx = 0;
          frame_idx++;
          frames_done++;
        end
      end
      prev_bclk = oAUD_BCLK;
    end
  end

  initial begin : driver
    // Reset, then a long idle with iENABLE low.
    repeat (5) @(negedge iCLK);
    outputs_idle("in_reset");
    iRST_N = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge iCLK);
      outputs_idle("idle_disabled");
    end

    // Pair presented before enable: entry frame underruns, pair follows.
    iL_DATA = 16'hA5C3;
    iR_DATA = 16'h0F0F;
    iVALID  = 1'b1;
    run_start();
    stream(3, M_ONE);

    // No source at all.
    run_start();
    stream(2, M_NONE);

    // Source always valid with counting samples.
    run_start();
    stream(5, M_COUNT);

    // Pair offered exactly on a load edge with the register empty.
    run_start();
    stream(4, M_AT_LOAD);

    // Random traffic.
    run_start();
    stream(6, M_RAND);

    // Abort at bit 20 with a pair held, restart 50 cycles later.
    iL_DATA = 16'h7E81;
    iR_DATA = 16'hC33C;
    iVALID  = 1'b1;
    run_start();
    @(negedge iCLK);
    check("ready_on_entry", oREADY, 1);
    @(negedge iCLK);
    iVALID = 1'b0;
    check("ready_after_accept", oREADY, 0);
    while (cyc < run_edge + BH + 20 * BIT_CYC + 4) @(negedge iCLK);
    check("lrck_at_bit20", oAUD_DACLRCK, 0);
    iENABLE = 1'b0;
    @(negedge iCLK);
    outputs_idle("abort_next_cycle");
    repeat (48) @(negedge iCLK);
    run_start();
    stream(2, M_NONE);

    // Asynchronous reset in the middle of a frame.
    iL_DATA = 16'h5AA5;
    iR_DATA = 16'h0001;
    iVALID  = 1'b1;
    run_start();
    while (cyc < run_edge + 300) @(negedge iCLK);
    iVALID = 1'b0;
    #3 iRST_N = 1'b0;
    #1 outputs_idle("async_reset");
    iENABLE = 1'b0;
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge iCLK);
      outputs_idle("idle_after_reset");
    end

    // Back to normal operation.
    run_start();
    stream(3, M_RAND);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
